// File: rtl/butterfly_pipe.sv
// butterfly_pipe: four-stage radix-2 DIT butterfly, Y = A + B*w, Z = A - B*w.
// Operands are packed complex {re, im}, each component a signed Q(DW-FW).FW value.
// Flow control: a transfer happens on a rising Clk edge when the valid and ready
// of that port are both high; all stages advance together when the output
// register is empty or being drained (adv), otherwise every stage holds.
// Build option BFLY_SAT_EN: out-of-range results clamp instead of wrapping.
module butterfly_pipe #(
    parameter int DW = 16,
    parameter int FW = 10
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] A,
    input  logic [2*DW-1:0] B,
    input  logic [2*DW-1:0] w,
    input  logic            inv,
    input  logic            scale,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] Y,
    output logic [2*DW-1:0] Z,
    output logic            ovf,
    input  logic            ovf_clr
);
    localparam int PW = 2 * DW;     // full product width
    localparam int CW = 2 * DW + 1; // combined product width
    localparam int SW = DW + 3;     // sum width ahead of range check

    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // Stage 1 registers
    logic            s1_v, s1_inv, s1_scale;
    logic [2*DW-1:0] s1_a, s1_b, s1_w;

    // Stage 1: capture operands and per-transaction mode bits.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            s1_v     <= 1'b0;
            s1_inv   <= 1'b0;
            s1_scale <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_w     <= '0;
        end else if (adv) begin
            s1_v     <= in_valid;
            s1_inv   <= inv;
            s1_scale <= scale;
            s1_a     <= A;
            s1_b     <= B;
            s1_w     <= w;
        end
    end

    logic signed [DW-1:0] b_re, b_im, w_re, w_im;
    assign b_re = s1_b[2*DW-1:DW];
    assign b_im = s1_b[DW-1:0];
    assign w_re = s1_w[2*DW-1:DW];
    assign w_im = s1_w[DW-1:0];

    // Stage 2 registers
    logic                 s2_v, s2_inv, s2_scale;
    logic [2*DW-1:0]      s2_a;
    logic signed [PW-1:0] s2_rr, s2_ii, s2_ri, s2_ir;

    // Stage 2: the four full-width partial products.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            s2_v     <= 1'b0;
            s2_inv   <= 1'b0;
            s2_scale <= 1'b0;
            s2_a     <= '0;
            s2_rr    <= '0;
            s2_ii    <= '0;
            s2_ri    <= '0;
            s2_ir    <= '0;
        end else if (adv) begin
            s2_v     <= s1_v;
            s2_inv   <= s1_inv;
            s2_scale <= s1_scale;
            s2_a     <= s1_a;
            s2_rr    <= PW'(b_re) * PW'(w_re);
            s2_ii    <= PW'(b_im) * PW'(w_im);
            s2_ri    <= PW'(b_re) * PW'(w_im);
            s2_ir    <= PW'(b_im) * PW'(w_re);
        end
    end

    logic signed [CW-1:0] pr_full, pi_full;

    // Complex product B*w, or B*conj(w) for an inverse transform.
    always_comb begin
        pr_full = '0;
        pi_full = '0;
        if (s2_inv) begin
            pr_full = CW'(s2_rr) + CW'(s2_ii);
            pi_full = CW'(s2_ir) - CW'(s2_ri);
        end else begin
            pr_full = CW'(s2_rr) - CW'(s2_ii);
            pi_full = CW'(s2_ri) + CW'(s2_ir);
        end
    end

    // Stage 3 registers; product kept at the sum width after the fraction shift
    logic                 s3_v, s3_scale;
    logic [2*DW-1:0]      s3_a;
    logic signed [SW-1:0] s3_pr, s3_pi;

    // Stage 3: drop FW fraction bits (floor) and register the product.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            s3_v     <= 1'b0;
            s3_scale <= 1'b0;
            s3_a     <= '0;
            s3_pr    <= '0;
            s3_pi    <= '0;
        end else if (adv) begin
            s3_v     <= s2_v;
            s3_scale <= s2_scale;
            s3_a     <= s2_a;
            s3_pr    <= SW'(pr_full >>> FW);
            s3_pi    <= SW'(pi_full >>> FW);
        end
    end

    // Optional halving, floor rounding.
    function automatic logic signed [SW-1:0] half_opt(input logic signed [SW-1:0] v,
                                                      input logic sc);
        return sc ? (v >>> 1) : v;
    endfunction

    // Range check against DW signed; returns {out_of_range, result}.
    function automatic logic [DW:0] fit(input logic signed [SW-1:0] v);
        logic          oor;
        logic [DW-1:0] r;
        oor = (v[SW-1:DW-1] != {(SW-DW+1){v[SW-1]}});
        r   = v[DW-1:0];
`ifdef BFLY_SAT_EN
        if (oor) r = v[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
        return {oor, r};
    endfunction

    logic signed [DW-1:0] a_re, a_im;
    logic signed [SW-1:0] yr, yi, zr, zi;
    logic [DW:0]          yr_f, yi_f, zr_f, zi_f;
    logic                 any_oor;
    assign a_re = s3_a[2*DW-1:DW];
    assign a_im = s3_a[DW-1:0];

    // Butterfly sums, optional scaling and range check for all four components.
    always_comb begin
        yr      = half_opt(SW'(a_re) + s3_pr, s3_scale);
        yi      = half_opt(SW'(a_im) + s3_pi, s3_scale);
        zr      = half_opt(SW'(a_re) - s3_pr, s3_scale);
        zi      = half_opt(SW'(a_im) - s3_pi, s3_scale);
        yr_f    = fit(yr);
        yi_f    = fit(yi);
        zr_f    = fit(zr);
        zi_f    = fit(zi);
        any_oor = yr_f[DW] | yi_f[DW] | zr_f[DW] | zi_f[DW];
    end

    // Stage 4: output register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            out_valid <= 1'b0;
            Y         <= '0;
            Z         <= '0;
        end else if (adv) begin
            out_valid <= s3_v;
            Y         <= {yr_f[DW-1:0], yi_f[DW-1:0]};
            Z         <= {zr_f[DW-1:0], zi_f[DW-1:0]};
        end
    end

    // Sticky overflow: set by a valid out-of-range result entering the output
    // register; a simultaneous clear loses to the set.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)                       ovf <= 1'b0;
        else if (adv && s3_v && any_oor) ovf <= 1'b1;
        else if (ovf_clr)               ovf <= 1'b0;
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: directed and random stimulus for butterfly_pipe against a
// plain-arithmetic complex model.
module tb_butterfly_pipe;
    localparam int DW = 16;
    localparam int FW = 10;
`ifdef BFLY_SAT_EN
    localparam logic [31:0] OVF_Y = 32'h7FFF_0000;
`else
    localparam logic [31:0] OVF_Y = 32'h8400_0000;
`endif

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0, B = '0, w = '0;
    logic        inv = 1'b0, scale = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] Y, Z;
    logic        ovf;
    logic        ovf_clr = 1'b0;

    int          total = 0;
    int          bad = 0;
    logic [64:0] exp_q[$];     // {overflow, Y, Z}
    logic        exp_ovf = 1'b0;
    bit          rand_rdy = 1'b0;

    butterfly_pipe #(.DW(DW), .FW(FW)) dut (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .w(w), .inv(inv), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready), .Y(Y), .Z(Z),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    // Clock and watchdog
    always #5 Clk = ~Clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] clip(input longint v);
        logic        o;
        logic [15:0] r;
        o = (v > 32767) || (v < -32768);
        r = v[15:0];
`ifdef BFLY_SAT_EN
        if (o) r = (v > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {o, r};
    endfunction

    // Reference: complex arithmetic on plain integers.
    function automatic logic [64:0] model(input logic [31:0] a, b, tw, input logic iv, sc);
        longint ar, ai, br, bi, wr, wi, pr, pi, yr, yi, zr, zi;
        logic [16:0] cyr, cyi, czr, czi;
        ar = $signed(a[31:16]);  ai = $signed(a[15:0]);
        br = $signed(b[31:16]);  bi = $signed(b[15:0]);
        wr = $signed(tw[31:16]); wi = $signed(tw[15:0]);
        if (iv) wi = -wi;
        pr = br * wr - bi * wi;
        pi = br * wi + bi * wr;
        pr = pr >>> FW;
        pi = pi >>> FW;
        yr = ar + pr; yi = ai + pi; zr = ar - pr; zi = ai - pi;
        if (sc) begin
            yr = yr >>> 1; yi = yi >>> 1; zr = zr >>> 1; zi = zi >>> 1;
        end
        cyr = clip(yr); cyi = clip(yi); czr = clip(zr); czi = clip(zi);
        return {cyr[16] | cyi[16] | czr[16] | czi[16],
                cyr[15:0], cyi[15:0], czr[15:0], czi[15:0]};
    endfunction

    function automatic logic [15:0] rand_w();
        int v;
        v = int'($urandom_range(0, 2048)) - 1024;
        return v[15:0];
    endfunction

    // Scoreboard: every output transfer is checked in order.
    always @(negedge Clk) begin
        if (Rst && out_valid && out_ready) begin
            logic [64:0] e;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL out_unexpected observed=%h expected=no_output", Y);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                exp_ovf = exp_ovf | e[64];
                chk("sb_y", Y, e[63:32]);
                chk("sb_z", Z, e[31:0]);
                chk("sb_ovf", ovf, exp_ovf);
            end
        end
    end

    // Driver tasks, all entered at posedge+1
    task automatic send(input logic [31:0] a, b, tw, input logic iv, sc);
        int n;
        bit done;
        n = 0; done = 0;
        A = a; B = b; w = tw; inv = iv; scale = sc; in_valid = 1'b1;
        while (!done && n < 200) begin
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge Clk);
            done = in_ready;
            @(posedge Clk);
            if (done) exp_q.push_back(model(a, b, tw, iv, sc));
            #1;
            n++;
        end
        in_valid = 1'b0;
        chk("send_accept", done, 1);
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        @(negedge Clk);
        while (!out_valid && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk({tag, "_seen"}, out_valid, 1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge Clk); #1;
            n++;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic basic_latency(input string tag);
        int lat;
        bit seen;
        A = 32'h0400_0000; B = 32'h0200_0000; w = 32'h0400_0000;
        inv = 1'b0; scale = 1'b0; in_valid = 1'b1;
        @(negedge Clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge Clk);
        exp_q.push_back(model(A, B, w, inv, scale));
        #1 in_valid = 1'b0;
        lat = 1; seen = 0;
        while (!seen && lat < 20) begin
            @(negedge Clk);
            if (out_valid) seen = 1;
            else begin
                @(posedge Clk);
                lat++;
            end
        end
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_y"}, Y, 32'h0600_0000);
        chk({tag, "_z"}, Z, 32'h0200_0000);
        chk({tag, "_ovf"}, ovf, 0);
        @(posedge Clk); #1;
    endtask

    logic [31:0] bp_a[6], bp_b[6];
    logic [31:0] y0, z0;
    int          idx;
    bit          acc;

    // Directed sequence followed by random traffic
    initial begin
        // Asynchronous reset with no clock edge involved
        #1 Rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", Y, 0);
        chk("rst_z", Z, 0);
        chk("rst_ovf", ovf, 0);
        #21 Rst = 1'b1;
        @(posedge Clk); #1;
        chk("rst_in_ready", in_ready, 1);

        // Basic forward butterfly and latency
        basic_latency("basic");
        drain("basic");

        // Forward then inverse, back to back
        send(32'h0, 32'h0000_0400, 32'h0000_0400, 1'b0, 1'b0);
        send(32'h0, 32'h0000_0400, 32'h0000_0400, 1'b1, 1'b0);
        wait_out("inv");
        chk("fwd_y", Y, 32'hFC00_0000);
        chk("fwd_z", Z, 32'h0400_0000);
        @(posedge Clk); @(negedge Clk);
        chk("inv_valid", out_valid, 1);
        chk("inv_y", Y, 32'h0400_0000);
        chk("inv_z", Z, 32'hFC00_0000);
        @(posedge Clk); #1;
        drain("inv");

        // Halving
        send(32'h0400_0000, 32'h0200_0000, 32'h0400_0000, 1'b0, 1'b1);
        wait_out("scale");
        chk("scale_y", Y, 32'h0300_0000);
        chk("scale_z", Z, 32'h0100_0000);
        @(posedge Clk); #1;
        drain("scale");

        // Overflow, sticky hold, clear
        send(32'h7C00_0000, 32'h0800_0000, 32'h0400_0000, 1'b0, 1'b0);
        wait_out("ovf");
        chk("ovf_y", Y, OVF_Y);
        chk("ovf_z", Z, 32'h7400_0000);
        chk("ovf_set", ovf, 1);
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        chk("ovf_held", ovf, 1);
        @(posedge Clk); #1 ovf_clr = 1'b1;
        @(posedge Clk); #1 ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        @(negedge Clk);
        chk("ovf_cleared", ovf, 0);

        // Clear held high while a new overflow lands: set wins
        @(posedge Clk); #1 ovf_clr = 1'b1;
        send(32'h7C00_0000, 32'h0800_0000, 32'h0400_0000, 1'b0, 1'b0);
        wait_out("ovf_clrset");
        chk("ovf_set_wins", ovf, 1);
        @(posedge Clk); #1 ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        @(negedge Clk);
        chk("ovf_clr_after", ovf, 0);
        @(posedge Clk); #1;
        drain("ovf");

        // Backpressure: six distinct inputs offered with out_ready low
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = 32'h0100_0040 * (i + 1);
            bp_b[i] = 32'h0080_0020 * (i + 1);
        end
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            A = bp_a[idx]; B = bp_b[idx]; w = 32'h0300_0100;
            inv = 1'b0; scale = 1'b0; in_valid = 1'b1;
            @(negedge Clk);
            acc = in_ready;
            @(posedge Clk);
            if (acc) begin
                exp_q.push_back(model(A, B, w, inv, scale));
                idx++;
            end
            #1;
        end
        chk("bp_accepted", idx, 4);
        @(negedge Clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        y0 = Y; z0 = Z;
        chk("bp_first_y", y0, exp_q[0][63:32]);
        repeat (3) @(negedge Clk);
        chk("bp_hold_y", Y, y0);
        chk("bp_hold_z", Z, z0);
        @(posedge Clk); #1 out_ready = 1'b1;
        send(bp_a[4], bp_b[4], 32'h0300_0100, 1'b0, 1'b0);
        send(bp_a[5], bp_b[5], 32'h0300_0100, 1'b0, 1'b0);
        drain("bp");

        // Random traffic with random backpressure and idle gaps
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send($urandom, $urandom, {rand_w(), rand_w()},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge Clk); #1;
            end
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain("rand");

        // Reset with transactions in flight and ovf set
        send(32'h7C00_0000, 32'h0800_0000, 32'h0400_0000, 1'b0, 1'b0);
        drain("pre_rst");
        send(32'h0400_0000, 32'h0200_0000, 32'h0400_0000, 1'b0, 1'b0);
        send(32'h0100_0100, 32'h0200_0000, 32'h0400_0000, 1'b1, 1'b0);
        send(32'h0200_0000, 32'h0200_0000, 32'h0400_0000, 1'b0, 1'b1);
        chk("mid_ovf_before", ovf, 1);
        #1 Rst = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_y", Y, 0);
        chk("mid_rst_z", Z, 0);
        chk("mid_rst_ovf", ovf, 0);
        exp_q.delete();
        exp_ovf = 1'b0;
        @(posedge Clk); #2 Rst = 1'b1;
        @(posedge Clk); #1;
        chk("mid_rst_empty", out_valid, 0);
        basic_latency("post_rst");
        drain("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
- Parametrised, pipelined radix-2 DIT butterfly for the FFT datapath.
- Computes Y = A + B·w and Z = A − B·w on packed complex operands {re, im}.
- Adds over the fixed Q6.10 butterfly:
  - generic width and fraction bits
  - valid/ready flow control with backpressure
  - per-transaction inverse-FFT mode (conjugate twiddle) and per-stage ÷2 scaling
  - sticky overflow status
- Sits between the stage operand buffers and the twiddle ROM in each FFT stage.

Parameters:
- DW, 16, bits per real/imag component (two's complement).
- FW, 10, fraction bits per component (Q(DW−FW).FW).

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block accepts operands this cycle.
- A  input  2*DW  {re[2DW−1:DW], im[DW−1:0]}.
- B  input  2*DW  same packing.
- w  input  2*DW  twiddle, same packing.
- inv  input  1  1: use conj(w) (inverse FFT); sampled with operands.
- scale  input  1  1: halve Y and Z (arithmetic >>1); sampled with operands.
- out_valid  output  1  Y/Z valid.
- out_ready  input  1  downstream accepts Y/Z.
- Y  output  2*DW  A + B·w.
- Z  output  2*DW  A − B·w.
- ovf  output  1  sticky: some result component exceeded DW range.
- ovf_clr  input  1  synchronous clear of ovf.

Behaviour:
- Reset (Rst=0, async): all stage valids, out_valid, Y, Z and ovf go to 0 immediately. Any in-flight data is discarded. in_ready=1 once reset is released.
- Pipeline enable: adv = out_ready | ~out_valid. in_ready = adv. Transfer occurs when in_valid & in_ready.
- When adv=0, every stage holds, and Y/Z/out_valid stay stable.
- Bubbles are not collapsed. Order is strictly preserved. Capacity is 4 transactions.
- Latency is 4 cycles from an accepted input edge to out_valid at adv=1.
- S1 registers A, B, w, inv, scale and valid.
- S2 forms four full-width signed products (2DW bits): Br·wr, Bi·wi, Br·wi, Bi·wr.
- S3 combines the products:
  - forward: Pr = Br·wr − Bi·wi, Pi = Br·wi + Bi·wr
  - inverse: Pr = Br·wr + Bi·wi, Pi = Bi·wr − Br·wi
  - Width is 2DW+1. Then arithmetic shift right by FW (floor/truncation).
- S4 computes each component at DW+3 bits: A±P, then >>1 (floor) if scale, then range-checked against DW signed.
  - In range: low DW bits are registered.
  - Out of range: see BFLY_SAT_EN.
- ovf is set when any of the four output components of a valid S4 result is out of range. It stays set until ovf_clr=1.
  - Set and clear in the same cycle: set wins.
  - Invalid (bubble) slots never set ovf.
- inv and scale are per-transaction. Changing them between back-to-back inputs affects only their own transaction.

Optional Feature:
- BFLY_SAT_EN defined: out-of-range components clamp to 2^(DW−1)−1 or −2^(DW−1).
- BFLY_SAT_EN undefined: out-of-range components wrap (low DW bits kept).
- ovf behaviour is identical in both builds.

Test Plan:
- Basic (DW=16, FW=10), A=0x0400_0000, B=0x0200_0000, w=0x0400_0000, inv=0, scale=0 -> 4 cycles later out_valid=1, Y=0x0600_0000, Z=0x0200_0000, ovf=0.
- Inverse: A=0, B=0x0000_0400, w=0x0000_0400:
  - inv=0 -> Y=0xFC00_0000, Z=0x0400_0000.
  - inv=1 on the next input -> Y=0x0400_0000, Z=0xFC00_0000, in that order.
- Scale: basic operands with scale=1 -> Y=0x0300_0000, Z=0x0100_0000.
- Overflow: A=0x7C00_0000, B=0x0800_0000, w=0x0400_0000:
  - SAT build -> Y=0x7FFF_0000; wrap build -> Y=0x8400_0000.
  - Both builds -> Z=0x7400_0000, ovf=1 held until ovf_clr pulse, then 0.
  - ovf_clr asserted together with a new overflow -> ovf stays 1.
- Backpressure: out_ready=0 with 6 consecutive distinct inputs offered -> exactly 4 accepted, then in_ready=0 and Y/Z held stable. out_ready=1 -> all 4 emitted in order, remaining inputs accepted, no loss or duplication.
- Reset mid-stream: Rst=0 while 3 transactions are in flight and ovf=1 -> out_valid, Y, Z, ovf are 0 without a clock edge. After release, a new basic input yields the correct result 4 cycles later.
